// File: rtl/wag_pkg.sv
// Shared types and default widths for the window address generator.
package wag_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } wag_state_t;

   // Default widths: address, image dimension, kernel size, stride
   localparam int WAG_ADDR_W = 17;
   localparam int WAG_DIM_W  = 10;
   localparam int WAG_K_W    = 3;
   localparam int WAG_S_W    = 2;

endpackage

// File: rtl/wag_wrap_cnt.sv
// Wrapping counter with enable, runtime terminal value and wrap pulse.
// "last" is high while the count sits at its limit; "wrap" is the enabled
// step that takes it back to zero, used to enable the next counter up.
module wag_wrap_cnt
   import wag_pkg::*;
#(
   parameter int W = 4
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         last,
   output logic         wrap
);

   logic [W-1:0] cnt;

   assign last = (cnt == limit);
   assign wrap = en && last;

   // count up on enable, fold back to zero once the limit is passed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= last ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/window_addr_gen.sv
// Walks a KxK window over an image and emits one address per handshake,
// ordered kx fastest, then ky, then ox, then oy.
// Addresses are built by adding row pitch / stride steps to pointers,
// never by multiplication, and wrap modulo 2^ADDR_W.
// Optional feature: WAG_ZERO_PAD_EN adds "same" zero padding and the pad output.
module window_addr_gen
   import wag_pkg::*;
#(
   parameter int ADDR_W = WAG_ADDR_W,
   parameter int DIM_W  = WAG_DIM_W,
   parameter int K_W    = WAG_K_W,
   parameter int S_W    = WAG_S_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [DIM_W-1:0]  img_w,
   input  logic [DIM_W-1:0]  img_h,
   input  logic [K_W-1:0]    k,
   input  logic [S_W-1:0]    stride,
   output logic              busy,
   output logic [ADDR_W-1:0] adrs,
   output logic              adrs_vld,
   input  logic              adrs_rdy,
   output logic              win_last,
`ifdef WAG_ZERO_PAD_EN
   output logic              pad,
`endif
   output logic              ack
);

   wag_state_t state, state_nxt;

   logic load, xfer;
   logic kx_last, ky_last, ox_last, oy_last;
   logic kx_wrap, ky_wrap, ox_wrap, oy_wrap;

   logic [1:0]        pad_in;
   logic              cfg_ok;
   logic [DIM_W:0]    span_w, span_h;
   logic [ADDR_W-1:0] pitch_in, pad_off, origin;

   logic [K_W-1:0]    k_lim_r;
   logic [DIM_W-1:0]  ow_lim_r, oh_lim_r;
   logic [ADDR_W-1:0] row_step_r, col_step_r, pitch_r;
   logic [ADDR_W-1:0] oy_ptr, win_ptr, row_ptr, adrs_r;

   // Stride is at most 3, so the output-grid division is a shift or a
   // divide by the constant 3.
   function automatic logic [DIM_W-1:0] div_stride(input logic [DIM_W:0] x,
                                                   input logic [S_W-1:0] s);
      logic [DIM_W:0] q;
      if (s == S_W'(2))
         q = x >> 1;
      else if (s == S_W'(3))
         q = x / (DIM_W+1)'(3);
      else
         q = x;
      return DIM_W'(q);
   endfunction

   assign load = (state == IDLE) && start;
   assign xfer = adrs_vld && adrs_rdy;

   // Scan setup derived from the live inputs, captured only on load
   always_comb begin
`ifdef WAG_ZERO_PAD_EN
      pad_in = 2'((k - K_W'(1)) >> 1);
`else
      pad_in = '0;
`endif
      span_w = (DIM_W+1)'(img_w) + (DIM_W+1)'({pad_in, 1'b0}) - (DIM_W+1)'(k);
      span_h = (DIM_W+1)'(img_h) + (DIM_W+1)'({pad_in, 1'b0}) - (DIM_W+1)'(k);
      cfg_ok = (k != '0) && (stride != '0) &&
               (DIM_W'(k) <= img_w) && (DIM_W'(k) <= img_h);
      pitch_in = '0;
      for (int i = 0; i < S_W; i++)
         if (stride[i]) pitch_in = pitch_in + (ADDR_W'(img_w) << i);
      pad_off = ADDR_W'(pad_in);
      for (int i = 0; i < 2; i++)
         if (pad_in[i]) pad_off = pad_off + (ADDR_W'(img_w) << i);
      origin = base - pad_off;
   end

   // Capture the scan configuration as counter limits and pointer steps
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_lim_r    <= '0;
         ow_lim_r   <= '0;
         oh_lim_r   <= '0;
         row_step_r <= '0;
         col_step_r <= '0;
         pitch_r    <= '0;
      end else if (load) begin
         k_lim_r    <= k - K_W'(1);
         ow_lim_r   <= div_stride(span_w, stride);
         oh_lim_r   <= div_stride(span_h, stride);
         row_step_r <= ADDR_W'(img_w);
         col_step_r <= ADDR_W'(stride);
         pitch_r    <= pitch_in;
      end
   end

   wag_wrap_cnt #(.W(K_W)) u_kx (
      .clk(clk), .rst_n(rst_n), .clr(load), .en(xfer),
      .limit(k_lim_r), .last(kx_last), .wrap(kx_wrap));

   wag_wrap_cnt #(.W(K_W)) u_ky (
      .clk(clk), .rst_n(rst_n), .clr(load), .en(kx_wrap),
      .limit(k_lim_r), .last(ky_last), .wrap(ky_wrap));

   wag_wrap_cnt #(.W(DIM_W)) u_ox (
      .clk(clk), .rst_n(rst_n), .clr(load), .en(ky_wrap),
      .limit(ow_lim_r), .last(ox_last), .wrap(ox_wrap));

   wag_wrap_cnt #(.W(DIM_W)) u_oy (
      .clk(clk), .rst_n(rst_n), .clr(load), .en(ox_wrap),
      .limit(oh_lim_r), .last(oy_last), .wrap(oy_wrap));

   // Pointer chain: output row -> window origin -> kernel row -> tap.
   // Each transfer steps the innermost pointer that has not hit its limit
   // and reloads everything below it from the new value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oy_ptr  <= '0;
         win_ptr <= '0;
         row_ptr <= '0;
         adrs_r  <= '0;
      end else if (load) begin
         oy_ptr  <= origin;
         win_ptr <= origin;
         row_ptr <= origin;
         adrs_r  <= origin;
      end else if (xfer) begin
         if (!kx_last) begin
            adrs_r <= adrs_r + 1'b1;
         end else if (!ky_last) begin
            row_ptr <= row_ptr + row_step_r;
            adrs_r  <= row_ptr + row_step_r;
         end else if (!ox_last) begin
            win_ptr <= win_ptr + col_step_r;
            row_ptr <= win_ptr + col_step_r;
            adrs_r  <= win_ptr + col_step_r;
         end else if (!oy_last) begin
            oy_ptr  <= oy_ptr + pitch_r;
            win_ptr <= oy_ptr + pitch_r;
            row_ptr <= oy_ptr + pitch_r;
            adrs_r  <= oy_ptr + pitch_r;
         end
      end
   end

`ifdef WAG_ZERO_PAD_EN
   localparam logic signed [DIM_W+1:0] POS_ONE = 1;

   logic signed [DIM_W+1:0] oy_pos, ox_pos, row_pos, col_pos;
   logic signed [DIM_W+1:0] pos_org, pos_org_r, pos_step_r;
   logic [DIM_W-1:0]        img_w_r, img_h_r;

   assign pos_org = -$signed((DIM_W+2)'(pad_in));

   // Signed tap coordinates mirror the pointer chain so out-of-image taps
   // can be recognised and masked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oy_pos     <= '0;
         ox_pos     <= '0;
         row_pos    <= '0;
         col_pos    <= '0;
         pos_org_r  <= '0;
         pos_step_r <= '0;
         img_w_r    <= '0;
         img_h_r    <= '0;
      end else if (load) begin
         oy_pos     <= pos_org;
         ox_pos     <= pos_org;
         row_pos    <= pos_org;
         col_pos    <= pos_org;
         pos_org_r  <= pos_org;
         pos_step_r <= $signed((DIM_W+2)'(stride));
         img_w_r    <= img_w;
         img_h_r    <= img_h;
      end else if (xfer) begin
         if (!kx_last) begin
            col_pos <= col_pos + POS_ONE;
         end else if (!ky_last) begin
            row_pos <= row_pos + POS_ONE;
            col_pos <= ox_pos;
         end else if (!ox_last) begin
            ox_pos  <= ox_pos + pos_step_r;
            row_pos <= oy_pos;
            col_pos <= ox_pos + pos_step_r;
         end else if (!oy_last) begin
            oy_pos  <= oy_pos + pos_step_r;
            row_pos <= oy_pos + pos_step_r;
            ox_pos  <= pos_org_r;
            col_pos <= pos_org_r;
         end
      end
   end

   assign pad  = adrs_vld && ((row_pos < 0) || (col_pos < 0) ||
                              (row_pos >= $signed({2'b00, img_h_r})) ||
                              (col_pos >= $signed({2'b00, img_w_r})));
   assign adrs = pad ? '0 : adrs_r;
`else
   assign adrs = adrs_r;
`endif

   assign win_last = adrs_vld && kx_last && ky_last;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state: bad configurations skip straight to DONE for the ACK
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = cfg_ok ? RUN : DONE;
         RUN:     if (oy_wrap) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      busy     = 1'b0;
      adrs_vld = 1'b0;
      ack      = 1'b0;
      case (state)
         RUN: begin
            busy     = 1'b1;
            adrs_vld = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            ack  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_window_addr_gen.sv
// Self-checking bench for window_addr_gen: expected beats are queued at
// stimulus time and a monitor pops and compares on every presented beat.
// Build with WAG_ZERO_PAD_EN defined to exercise the padded variant.
module tb_window_addr_gen;

   typedef struct packed {
      logic [16:0] adrs;
      logic        last;
      logic        pad;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [16:0] base = '0;
   logic [9:0]  img_w = '0;
   logic [9:0]  img_h = '0;
   logic [2:0]  k = '0;
   logic [1:0]  stride = '0;
   logic        busy, adrs_vld, win_last, ack;
   logic [16:0] adrs;
   logic        adrs_rdy = 1'b1;
   logic        pad_obs;
`ifdef WAG_ZERO_PAD_EN
   logic        pad;
   assign pad_obs = pad;
`else
   assign pad_obs = 1'b0;
`endif

   int    nVec = 0;
   int    nFail = 0;
   int    cyc = 0;
   int    ackCount = 0;
   int    lastXferCyc = 0;
   bit    rdyRandom = 0;
   beat_t sb[$];
   beat_t got[$];
   beat_t obs, expd;

   window_addr_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base),
      .img_w(img_w), .img_h(img_h), .k(k), .stride(stride),
      .busy(busy), .adrs(adrs), .adrs_vld(adrs_vld), .adrs_rdy(adrs_rdy),
      .win_last(win_last),
`ifdef WAG_ZERO_PAD_EN
      .pad(pad),
`endif
      .ack(ack));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      adrs_rdy = rdyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented beat (stalled or not) must match the head
   // of the expected queue; the head is consumed on transfer
   always @(negedge clk) begin
      if (ack) ackCount++;
      if (rst_n && adrs_vld) begin
         obs.adrs = adrs;
         obs.last = win_last;
         obs.pad  = pad_obs;
         if (sb.size() == 0) begin
            checkOutput("unexpected beat", 32'(adrs), 32'hFFFFFFFF);
         end else begin
            expd = sb[0];
            checkOutput("adrs", 32'(adrs), 32'(expd.adrs));
            checkOutput("win_last", 32'(win_last), 32'(expd.last));
`ifdef WAG_ZERO_PAD_EN
            checkOutput("pad", 32'(pad_obs), 32'(expd.pad));
`endif
            if (adrs_rdy) begin
               void'(sb.pop_front());
               got.push_back(obs);
               lastXferCyc = cyc;
            end
         end
      end
   end

   // Reference model: direct address formula over the output grid
   function automatic int pushModel(input logic [16:0] b, input int w, input int h,
                                    input int kk, input int s);
      int p, ow, oh, n, r, c;
      beat_t e;
      p = 0;
      n = 0;
`ifdef WAG_ZERO_PAD_EN
      p = (kk - 1) / 2;
`endif
      if (kk > 0 && s > 0 && kk <= w && kk <= h) begin
         ow = (w + 2*p - kk) / s + 1;
         oh = (h + 2*p - kk) / s + 1;
         for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
               for (int ky = 0; ky < kk; ky++)
                  for (int kx = 0; kx < kk; kx++) begin
                     r = oy*s + ky - p;
                     c = ox*s + kx - p;
                     e.pad  = (r < 0) || (r >= h) || (c < 0) || (c >= w);
                     e.adrs = e.pad ? 17'd0 : 17'(int'(b) + r*w + c);
                     e.last = (ky == kk-1) && (kx == kk-1);
                     sb.push_back(e);
                     n++;
                  end
      end
      return n;
   endfunction

   task automatic launch(input logic [16:0] b, input int w, input int h,
                         input int kk, input int s, output int startCyc);
      @(posedge clk);
      #1;
      base = b; img_w = 10'(w); img_h = 10'(h); k = 3'(kk); stride = 2'(s);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      startCyc = cyc;
      base = 17'($urandom); img_w = 10'($urandom); img_h = 10'($urandom);
      k = 3'($urandom); stride = 2'($urandom);
   endtask

   task automatic applyStimulus(input logic [16:0] b, input int w, input int h,
                                input int kk, input int s);
      int n, startCyc, ackAt, ackBefore;
      bit ackSeen;
      got.delete();
      sb.delete();
      n = pushModel(b, w, h, kk, s);
      ackBefore = ackCount;
      ackSeen = 0;
      ackAt = 0;
      launch(b, w, h, kk, s, startCyc);
      @(negedge clk);
      checkOutput("vld after start", 32'(adrs_vld), 32'(n > 0));
      if (ack) begin ackSeen = 1; ackAt = cyc; end
      for (int i = 0; i < 4000 && !ackSeen; i++) begin
         @(negedge clk);
         if (ack) begin ackSeen = 1; ackAt = cyc; end
      end
      checkOutput("ack seen", 32'(ackSeen), 32'd1);
      if (ackSeen) begin
         checkOutput("ack latency", 32'(ackAt), 32'(n > 0 ? lastXferCyc + 1 : startCyc));
         checkOutput("vld at ack", 32'(adrs_vld), 32'd0);
         checkOutput("busy at ack", 32'(busy), 32'd1);
      end
      checkOutput("beats left", 32'(sb.size()), 32'd0);
      checkOutput("beats seen", 32'(got.size()), 32'(n));
      @(negedge clk);
      #1;
      checkOutput("busy after ack", 32'(busy), 32'd0);
      checkOutput("ack one cycle", 32'(ack), 32'd0);
      checkOutput("ack count", 32'(ackCount - ackBefore), 32'd1);
      sb.delete();
   endtask

   task automatic checkBeat(input string tag, input int idx, input logic [16:0] exp);
      checkOutput($sformatf("%s beat %0d", tag, idx),
                  idx < got.size() ? 32'(got[idx].adrs) : 32'hDEADBEEF, 32'(exp));
   endtask

   task automatic checkFirstWindow(input string tag);
      int c1[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
      for (int i = 0; i < 9; i++) checkBeat(tag, i, 17'(c1[i]));
   endtask

`ifndef WAG_ZERO_PAD_EN
   task automatic resetMidScan();
      int n, startCyc, ackBefore;
      got.delete();
      sb.delete();
      n = pushModel(17'd0, 5, 5, 3, 1);
      ackBefore = ackCount;
      launch(17'd0, 5, 5, 3, 1, startCyc);
      for (int i = 0; i < 500 && got.size() < 12; i++) @(negedge clk);
      checkOutput("reached window 2", 32'(got.size() >= 12), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst vld", 32'(adrs_vld), 32'd0);
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst adrs", 32'(adrs), 32'd0);
      checkOutput("rst win_last", 32'(win_last), 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      checkOutput("no ack after reset", 32'(ackCount - ackBefore), 32'd0);
      checkOutput("idle after reset", 32'(busy), 32'd0);
   endtask
`endif

   initial begin
      #12;
      checkOutput("reset vld", 32'(adrs_vld), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset ack", 32'(ack), 32'd0);
      checkOutput("reset win_last", 32'(win_last), 32'd0);
      checkOutput("reset adrs", 32'(adrs), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

`ifndef WAG_ZERO_PAD_EN
      $display("[TB] case 1: 5x5 K3 S1");
      applyStimulus(17'd0, 5, 5, 3, 1);
      checkOutput("c1 count", 32'(got.size()), 32'd81);
      checkFirstWindow("c1");
      checkBeat("c1", 80, 17'd24);
      checkOutput("c1 last flag 9", 32'(got.size() > 8 ? got[8].last : 1'b0), 32'd1);

      $display("[TB] case 2: 5x5 K3 S2");
      applyStimulus(17'd0, 5, 5, 3, 2);
      checkOutput("c2 count", 32'(got.size()), 32'd36);
      checkBeat("c2", 0, 17'd0);
      checkBeat("c2", 9, 17'd2);
      checkBeat("c2", 18, 17'd10);
      checkBeat("c2", 27, 17'd12);
      checkBeat("c2", 35, 17'd24);

      $display("[TB] case 3: random ready");
      rdyRandom = 1;
      applyStimulus(17'd0, 5, 5, 3, 1);
      rdyRandom = 0;
      checkOutput("c3 count", 32'(got.size()), 32'd81);
      checkFirstWindow("c3");
      checkBeat("c3", 80, 17'd24);

      $display("[TB] case 6: reset mid-scan");
      resetMidScan();
      applyStimulus(17'd0, 5, 5, 3, 1);
      checkOutput("c6 count", 32'(got.size()), 32'd81);
      checkFirstWindow("c6");
`else
      $display("[TB] case 7: padded 3x3 K3 S1");
      applyStimulus(17'd0, 3, 3, 3, 1);
      checkOutput("c7 count", 32'(got.size()), 32'd81);
      begin
         int padPat[9] = '{1, 1, 1, 1, 0, 0, 1, 0, 0};
         for (int i = 0; i < 9; i++)
            checkOutput($sformatf("c7 pad %0d", i),
                        i < got.size() ? 32'(got[i].pad) : 32'hDEADBEEF, 32'(padPat[i]));
      end
      checkBeat("c7", 4, 17'd0);
      checkBeat("c7", 5, 17'd1);
      checkBeat("c7", 7, 17'd3);
      checkBeat("c7", 8, 17'd4);
`endif

      $display("[TB] case 4: address wrap");
      applyStimulus(17'h1FFFE, 2, 2, 2, 1);
      checkOutput("c4 count", 32'(got.size()), 32'd4);
      checkBeat("c4", 0, 17'h1FFFE);
      checkBeat("c4", 1, 17'h1FFFF);
      checkBeat("c4", 2, 17'h00000);
      checkBeat("c4", 3, 17'h00001);

      $display("[TB] case 5: kernel larger than image");
      applyStimulus(17'd0, 3, 3, 4, 1);
      checkOutput("c5 count", 32'(got.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
